regfile_scoreboard: RTL and testbench

- Parametrised successor to the single-write register file: 2 combinational read ports, 2 synchronous write-back ports, and write-to-read bypass.
- Adds a per-register pending-write scoreboard for decode-stage hazard detection, an optional hardwired zero register, and a flush that clears all pending state.
- Sits between the decode stage (read and issue) and the MEM/WB stages (write-back).

---
 rtl/regfile_scoreboard_if.sv | 35 +++
 rtl/regfile_scoreboard.sv | 124 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/write-back bundle for regfile_scoreboard: read ports, issue, two write-back
// ports, flush and the busy count.
interface regfile_scoreboard_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rs1_addr;
   logic [ADDR_W-1:0] rs2_addr;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;
   logic              rs1_ready;
   logic              rs2_ready;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_rd;
   logic              wb0_en;
   logic [ADDR_W-1:0] wb0_addr;
   logic [DATA_W-1:0] wb0_data;
   logic              wb1_en;
   logic [ADDR_W-1:0] wb1_addr;
   logic [DATA_W-1:0] wb1_data;
   logic              flush;
   logic [ADDR_W:0]   busy_count;

   modport master (
      output rs1_addr, rs2_addr, issue_valid, issue_rd,
             wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data, flush,
      input  rs1_data, rs2_data, rs1_ready, rs2_ready, busy_count
   );

   modport slave (
      input  rs1_addr, rs2_addr, issue_valid, issue_rd,
             wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data, flush,
      output rs1_data, rs2_data, rs1_ready, rs2_ready, busy_count
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Two-read / two-write register file with same-cycle write-back bypass and a
// per-register pending-write scoreboard for decode hazard detection.
module regfile_scoreboard_rd #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              rd_ok,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] arr_data,
   input  logic              arr_busy,
   input  logic              wb0_ok,
   input  logic [ADDR_W-1:0] wb0_addr,
   input  logic [DATA_W-1:0] wb0_data,
   input  logic              wb1_ok,
   input  logic [ADDR_W-1:0] wb1_addr,
   input  logic [DATA_W-1:0] wb1_data,
   output logic [DATA_W-1:0] data,
   output logic              ready
);
   logic hit0, hit1;

   assign hit0 = rd_ok && wb0_ok && (wb0_addr == rd_addr);
   assign hit1 = rd_ok && wb1_ok && (wb1_addr == rd_addr);

   // wb1 is the later pipeline path, so it overrides wb0 and the array
   always_comb begin
      data  = '0;
      ready = 1'b1;
      if (rd_ok) begin
         data  = hit1 ? wb1_data : (hit0 ? wb0_data : arr_data);
         ready = hit0 || hit1 || !arr_busy;
      end
   end
endmodule

module regfile_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32,
   parameter int ZERO_REG = 1
) (
   input  logic clk,
   input  logic rst_n,
   regfile_scoreboard_if.slave bus
);
   localparam int NUM_RD = 2;
   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic [NUM_REGS-1:0]             busy, busy_nxt;
   logic [ADDR_W:0]                 cnt;

   logic [NUM_RD-1:0][ADDR_W-1:0]   rd_addr;
   logic [NUM_RD-1:0][DATA_W-1:0]   rd_data;
   logic [NUM_RD-1:0]               rd_ready;

   logic wb0_ok, wb1_ok, iss_ok;

   // Out-of-range addresses and (optionally) r0 are never stored or tracked
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ({{(32-ADDR_W){1'b0}}, a} < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
      return IDX_W'(a);
   endfunction

   assign wb0_ok = bus.wb0_en && addr_ok(bus.wb0_addr);
   assign wb1_ok = bus.wb1_en && addr_ok(bus.wb1_addr);
   assign iss_ok = bus.issue_valid && addr_ok(bus.issue_rd);

   assign rd_addr[0] = bus.rs1_addr;
   assign rd_addr[1] = bus.rs2_addr;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic ok;
      assign ok = addr_ok(rd_addr[p]);
      regfile_scoreboard_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
         .rd_ok    (ok),
         .rd_addr  (rd_addr[p]),
         .arr_data (ok ? regs[idx(rd_addr[p])] : '0),
         .arr_busy (ok ? busy[idx(rd_addr[p])] : 1'b0),
         .wb0_ok   (wb0_ok),
         .wb0_addr (bus.wb0_addr),
         .wb0_data (bus.wb0_data),
         .wb1_ok   (wb1_ok),
         .wb1_addr (bus.wb1_addr),
         .wb1_data (bus.wb1_data),
         .data     (rd_data[p]),
         .ready    (rd_ready[p])
      );
   end

   assign bus.rs1_data  = rd_data[0];
   assign bus.rs2_data  = rd_data[1];
   assign bus.rs1_ready = rd_ready[0];
   assign bus.rs2_ready = rd_ready[1];

   // Issue is applied last so a same-cycle write-back cannot retire the new producer
   always_comb begin
      busy_nxt = bus.flush ? '0 : busy;
      if (wb0_ok) busy_nxt[idx(bus.wb0_addr)] = 1'b0;
      if (wb1_ok) busy_nxt[idx(bus.wb1_addr)] = 1'b0;
      if (iss_ok) busy_nxt[idx(bus.issue_rd)] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         regs <= '0;
         busy <= '0;
      end else begin
         if (wb0_ok) regs[idx(bus.wb0_addr)] <= bus.wb0_data;
         if (wb1_ok) regs[idx(bus.wb1_addr)] <= bus.wb1_data;
         busy <= busy_nxt;
      end
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < NUM_REGS; i++) cnt = cnt + (ADDR_W+1)'(busy[i]);
   end

   assign bus.busy_count = cnt;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: stimulus queues hand-computed expectations, a negedge monitor
// compares them against two instances (zero register on, and off with 16 registers).
module tb_regfile_scoreboard;
   localparam int DW = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0] rs1_addr, rs2_addr, issue_rd, wb0_addr, wb1_addr;
   logic [DW-1:0] wb0_data, wb1_data;
   logic          issue_valid, wb0_en, wb1_en, flush;

   regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus_z ();
   regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus_n ();

   assign bus_z.rs1_addr = rs1_addr;    assign bus_n.rs1_addr = rs1_addr;
   assign bus_z.rs2_addr = rs2_addr;    assign bus_n.rs2_addr = rs2_addr;
   assign bus_z.issue_valid = issue_valid; assign bus_n.issue_valid = issue_valid;
   assign bus_z.issue_rd = issue_rd;    assign bus_n.issue_rd = issue_rd;
   assign bus_z.wb0_en = wb0_en;        assign bus_n.wb0_en = wb0_en;
   assign bus_z.wb0_addr = wb0_addr;    assign bus_n.wb0_addr = wb0_addr;
   assign bus_z.wb0_data = wb0_data;    assign bus_n.wb0_data = wb0_data;
   assign bus_z.wb1_en = wb1_en;        assign bus_n.wb1_en = wb1_en;
   assign bus_z.wb1_addr = wb1_addr;    assign bus_n.wb1_addr = wb1_addr;
   assign bus_z.wb1_data = wb1_data;    assign bus_n.wb1_data = wb1_data;
   assign bus_z.flush = flush;          assign bus_n.flush = flush;

   regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32), .ZERO_REG(1)) u_z (
      .clk(clk), .rst_n(rst_n), .bus(bus_z.slave));
   regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(16), .ZERO_REG(0)) u_n (
      .clk(clk), .rst_n(rst_n), .bus(bus_n.slave));

   typedef enum int {Z_D1, Z_D2, Z_R1, Z_R2, Z_BC, N_D1, N_R1, N_BC} sig_e;
   typedef struct {
      string       name;
      sig_e        sig;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   bit   stim_done = 1'b0;

   function automatic logic [31:0] sample(input sig_e s);
      case (s)
         Z_D1:    return bus_z.rs1_data;
         Z_D2:    return bus_z.rs2_data;
         Z_R1:    return 32'(bus_z.rs1_ready);
         Z_R2:    return 32'(bus_z.rs2_ready);
         Z_BC:    return 32'(bus_z.busy_count);
         N_D1:    return bus_n.rs1_data;
         N_R1:    return 32'(bus_n.rs1_ready);
         default: return 32'(bus_n.busy_count);
      endcase
   endfunction

   // Monitor: outputs are combinational, so everything queued this cycle is due now
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         logic [31:0] act;
         e = q.pop_front();
         act = sample(e.sig);
         n_chk++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
         end
      end
   end

   task automatic expect_v(input string name, input sig_e s, input logic [31:0] v);
      q.push_back('{name, s, v});
   endtask

   // Advance one cycle and return all inputs to idle
   task automatic step();
      @(posedge clk);
      #1;
      rs1_addr = '0; rs2_addr = '0; issue_valid = 0; issue_rd = '0;
      wb0_en = 0; wb0_addr = '0; wb0_data = '0;
      wb1_en = 0; wb1_addr = '0; wb1_data = '0; flush = 0;
   endtask

   initial begin
      rs1_addr = '0; rs2_addr = '0; issue_valid = 0; issue_rd = '0;
      wb0_en = 0; wb0_addr = '0; wb0_data = '0;
      wb1_en = 0; wb1_addr = '0; wb1_data = '0; flush = 0;

      // Reset for two edges; the second edge also sees a write and issue to r5
      step();
      wb0_en = 1; wb0_addr = 5; wb0_data = 32'hAAAA; issue_valid = 1; issue_rd = 5;
      step();
      rst_n = 1; rs1_addr = 5; rs2_addr = 31;
      expect_v("rst_rs1_data", Z_D1, 0);  expect_v("rst_rs2_data", Z_D2, 0);
      expect_v("rst_rs1_rdy", Z_R1, 1);   expect_v("rst_rs2_rdy", Z_R2, 1);
      expect_v("rst_busy", Z_BC, 0);      expect_v("rst_n_busy", N_BC, 0);

      step(); wb0_en = 1; wb0_addr = 7; wb0_data = 32'hDEADBEEF; rs1_addr = 7;
      expect_v("bypass_wb0", Z_D1, 32'hDEADBEEF); expect_v("bypass_rdy", Z_R1, 1);
      step(); rs1_addr = 7;
      expect_v("array_r7", Z_D1, 32'hDEADBEEF);

      step(); wb0_en = 1; wb0_addr = 3; wb0_data = 32'h11;
      wb1_en = 1; wb1_addr = 3; wb1_data = 32'h22; rs1_addr = 3; rs2_addr = 3;
      expect_v("dual_byp_rs1", Z_D1, 32'h22); expect_v("dual_byp_rs2", Z_D2, 32'h22);
      step(); rs1_addr = 3; rs2_addr = 3;
      expect_v("dual_arr_rs1", Z_D1, 32'h22); expect_v("dual_arr_rs2", Z_D2, 32'h22);

      // r0: hardwired on u_z, ordinary storage on u_n
      step(); wb0_en = 1; wb0_addr = 0; wb0_data = 32'hFFFF; issue_valid = 1; issue_rd = 0; rs1_addr = 0;
      expect_v("z_r0_byp", Z_D1, 0);  expect_v("z_r0_rdy", Z_R1, 1);
      expect_v("n_r0_byp", N_D1, 32'hFFFF); expect_v("n_r0_byp_rdy", N_R1, 1);
      step(); rs1_addr = 0;
      expect_v("z_r0_arr", Z_D1, 0);  expect_v("z_r0_rdy2", Z_R1, 1); expect_v("z_r0_busy", Z_BC, 0);
      expect_v("n_r0_arr", N_D1, 32'hFFFF); expect_v("n_r0_rdy2", N_R1, 0); expect_v("n_r0_busy", N_BC, 1);
      step(); wb1_en = 1; wb1_addr = 0; wb1_data = 32'hFFFF; rs1_addr = 0;
      expect_v("n_r0_wb_rdy", N_R1, 1);

      // Scoreboard on r9
      step(); issue_valid = 1; issue_rd = 9; rs2_addr = 9;
      expect_v("iss_same_rdy", Z_R2, 1); expect_v("iss_same_busy", Z_BC, 0); expect_v("n_busy_clr", N_BC, 0);
      step(); rs2_addr = 9;
      expect_v("r9_busy_rdy", Z_R2, 0); expect_v("r9_busy_cnt", Z_BC, 1); expect_v("r9_busy_data", Z_D2, 0);
      step(); wb1_en = 1; wb1_addr = 9; wb1_data = 32'h55; rs2_addr = 9;
      expect_v("r9_wb_rdy", Z_R2, 1); expect_v("r9_wb_data", Z_D2, 32'h55); expect_v("r9_wb_cnt", Z_BC, 1);
      step(); rs2_addr = 9;
      expect_v("r9_done_cnt", Z_BC, 0); expect_v("r9_done_rdy", Z_R2, 1); expect_v("r9_done_data", Z_D2, 32'h55);
      step(); issue_valid = 1; issue_rd = 9; wb0_en = 1; wb0_addr = 9; wb0_data = 32'h66; rs2_addr = 9;
      expect_v("r9_isswb_rdy", Z_R2, 1); expect_v("r9_isswb_data", Z_D2, 32'h66);
      step(); rs2_addr = 9;
      expect_v("r9_kept_rdy", Z_R2, 0); expect_v("r9_kept_cnt", Z_BC, 1); expect_v("r9_kept_data", Z_D2, 32'h66);
      step(); wb0_en = 1; wb0_addr = 9; wb0_data = 32'h77; rs2_addr = 9;
      expect_v("r9_clr_data", Z_D2, 32'h77);

      // Flush sequence
      step(); issue_valid = 1; issue_rd = 1; rs1_addr = 1;
      expect_v("fl_cnt0", Z_BC, 0);
      step(); issue_valid = 1; issue_rd = 2;
      expect_v("fl_cnt1", Z_BC, 1);
      step(); issue_valid = 1; issue_rd = 4;
      expect_v("fl_cnt2", Z_BC, 2);
      step(); flush = 1; issue_valid = 1; issue_rd = 6; rs1_addr = 4; rs2_addr = 6;
      expect_v("fl_cnt3", Z_BC, 3); expect_v("fl_r4_busy", Z_R1, 0); expect_v("fl_r6_pre", Z_R2, 1);
      step(); rs1_addr = 4; rs2_addr = 6;
      expect_v("fl_after_cnt", Z_BC, 1); expect_v("fl_r4_rdy", Z_R1, 1); expect_v("fl_r6_busy", Z_R2, 0);
      step(); rs1_addr = 1; rs2_addr = 2;
      expect_v("fl_r1_rdy", Z_R1, 1); expect_v("fl_r2_rdy", Z_R2, 1);

      // r20 is out of range for the 16-register instance
      step(); wb0_en = 1; wb0_addr = 20; wb0_data = 32'h1234; issue_valid = 1; issue_rd = 20; rs1_addr = 20;
      expect_v("z_r20_byp", Z_D1, 32'h1234); expect_v("n_r20_byp", N_D1, 0); expect_v("n_r20_rdy", N_R1, 1);
      step(); rs1_addr = 20;
      expect_v("z_r20_arr", Z_D1, 32'h1234); expect_v("z_r20_busy", Z_R1, 0); expect_v("z_cnt2", Z_BC, 2);
      expect_v("n_r20_arr", N_D1, 0); expect_v("n_r20_rdy2", N_R1, 1); expect_v("n_cnt1", N_BC, 1);

      stim_done = 1'b1;
   end

   initial begin
      int budget;
      budget = 0;
      while (!(stim_done && q.size() == 0) && budget < 2000) begin
         @(posedge clk);
         budget++;
      end
      if (q.size() != 0 || !stim_done) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d expectations pending, expected 0 after %0d cycles", q.size(), budget);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
